// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and parity modes.
// Also used by the receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int unsigned DATA_BITS = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear restarts the count at 0 on the next cycle.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   output logic bit_end_o
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   assign bit_end_o = (cnt_q == LastCnt);

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clear_i || bit_end_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// All outputs come straight from flops.
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TX_start,
   input  logic [7:0] TX_data,
   output logic       TX_out,
   output logic       TX_busy,
   output logic       TX_done
);

   import uart_pkg::*;

   localparam logic       ParMode  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
   localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

   uart_state_e          state_d, state_q;
   logic [2:0]           bit_cnt_d, bit_cnt_q;
   logic [DATA_BITS-1:0] shift_d, shift_q;
   logic                 par_d, par_q;
   logic                 tx_out_d, tx_out_q;
   logic                 busy_d, busy_q;
   logic                 done_d, done_q;
   logic                 clear;
   logic                 bit_end;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk_i     (CLK),
      .rst_ni    (RST),
      .clear_i   (clear),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (TX_start) begin
               shift_d = TX_data;
               par_d   = calc_parity(TX_data, ParMode);
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // bit_cnt is reused to count stop bits
            if (bit_end) begin
               if (bit_cnt_q == LastStop) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      clear  = (state_q == IDLE) || (state_d != state_q);
      busy_d = (state_d != IDLE);

      unique case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
         PARITY:  tx_out_d = par_d;
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign TX_out  = tx_out_q;
   assign TX_busy = busy_q;
   assign TX_done = done_q;

endmodule
